// File: rtl/fp_convert_pipe.sv
// Pipelined linear-to-floating-point converter.
// A signed sample becomes sign / exponent / mantissa / saturate, where the encoded
// magnitude is man * 2^exp. Three register stages (sign-magnitude, normalise,
// extract/round) advance together on a single enable, so a stalled output
// freezes the whole pipe, and bubbles stay in their slots.
module fp_convert_pipe #(
    parameter int unsigned IN_W     = 12,
    parameter int unsigned EXP_W    = 3,
    parameter int unsigned MAN_W    = 4,
    parameter int unsigned ROUND_EN = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_sign_o,
    output logic [EXP_W-1:0] out_exp_o,
    output logic [MAN_W-1:0] out_man_o,
    output logic             out_sat_o
);

    // Shift amounts never exceed IN_W-MAN_W+1, so this width is always enough.
    localparam int unsigned SH_W    = $clog2(IN_W) + 1;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

    // Global pipeline enable: everything moves unless the output is held.
    logic en;
    assign en         = !out_valid_o || out_ready_i;
    assign in_ready_o = en;

    // ------------------------------------------------------------------
    // Stage 1: sign / magnitude
    // ------------------------------------------------------------------
    logic            s1_valid_q;
    logic            s1_sign_q, s1_sign_d;
    logic [IN_W-1:0] s1_mag_q, s1_mag_d;

    // Magnitude is IN_W bits unsigned, so the most negative input maps to 2^(IN_W-1).
    always_comb begin
        s1_sign_d = in_data_i[IN_W-1];
        s1_mag_d  = in_data_i;
        if (in_data_i[IN_W-1]) begin
            s1_mag_d = ~in_data_i + {{(IN_W-1){1'b0}}, 1'b1};
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
        end else if (en) begin
            s1_valid_q <= in_valid_i;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: normalise
    // ------------------------------------------------------------------
    logic            s2_valid_q;
    logic            s2_sign_q;
    logic [IN_W-1:0] s2_mag_q;
    logic [SH_W-1:0] s2_exp_q, s2_exp_d;
    logic            s2_presat_q, s2_presat_d;
    logic [SH_W-1:0] msb_pos;

    // Leading-one position; the last hit in the ascending scan is the highest bit.
    always_comb begin
        msb_pos = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (s1_mag_q[i]) begin
                msb_pos = SH_W'(i);
            end
        end
    end

    // Exponent is how far the leading one sits above the mantissa's top bit.
    always_comb begin
        s2_exp_d = '0;
        if (msb_pos > SH_W'(MAN_W - 1)) begin
            s2_exp_d = msb_pos - SH_W'(MAN_W - 1);
        end
        s2_presat_d = 32'(s2_exp_d) > EXP_MAX;
    end

    // Stage 2 registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_mag_q    <= '0;
            s2_exp_q    <= '0;
            s2_presat_q <= 1'b0;
        end else if (en) begin
            s2_valid_q  <= s1_valid_q;
            s2_sign_q   <= s1_sign_q;
            s2_mag_q    <= s1_mag_q;
            s2_exp_q    <= s2_exp_d;
            s2_presat_q <= s2_presat_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: extract mantissa, round, saturate
    // ------------------------------------------------------------------
    logic [IN_W-1:0]  mag_sh;
    logic [IN_W-1:0]  rnd_mask;
    logic             rnd_bit;
    logic [MAN_W-1:0] man_trunc;
    logic [MAN_W-1:0] man_rnd;
    logic [SH_W-1:0]  exp_rnd;
    logic             sat;
    logic             unused_mag_hi;

    // After normalisation the shifted magnitude always fits in MAN_W bits.
    assign mag_sh        = s2_mag_q >> s2_exp_q;
    assign man_trunc     = mag_sh[MAN_W-1:0];
    assign unused_mag_hi = ^mag_sh[IN_W-1:MAN_W];

    // Round bit is the first discarded bit; the denormal range (exp 0) never rounds.
    always_comb begin
        rnd_mask = '0;
        rnd_bit  = 1'b0;
        if ((ROUND_EN != 0) && (s2_exp_q != '0)) begin
            rnd_mask = {{(IN_W-1){1'b0}}, 1'b1} << (s2_exp_q - SH_W'(1));
            rnd_bit  = |(s2_mag_q & rnd_mask);
        end
    end

    // Apply rounding; an all-ones mantissa carries out and renormalises.
    always_comb begin
        man_rnd = man_trunc;
        exp_rnd = s2_exp_q;
        if (rnd_bit) begin
            if (&man_trunc) begin
                man_rnd = {1'b1, {(MAN_W-1){1'b0}}};
                exp_rnd = s2_exp_q + SH_W'(1);
            end else begin
                man_rnd = man_trunc + {{(MAN_W-1){1'b0}}, 1'b1};
            end
        end
        sat = s2_presat_q || (32'(exp_rnd) > EXP_MAX);
    end

    // Output registers; fields hold whenever the consumer stalls.
    logic             out_valid_q;
    logic             out_sign_q;
    logic [EXP_W-1:0] out_exp_q;
    logic [MAN_W-1:0] out_man_q;
    logic             out_sat_q;

    // Stage 3 registers, clamped to the largest code on saturation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_man_q   <= '0;
            out_sat_q   <= 1'b0;
        end else if (en) begin
            out_valid_q <= s2_valid_q;
            out_sign_q  <= s2_sign_q;
            out_sat_q   <= sat;
            if (sat) begin
                out_exp_q <= EXP_W'(EXP_MAX);
                out_man_q <= '1;
            end else begin
                out_exp_q <= EXP_W'(exp_rnd);
                out_man_q <= man_rnd;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_sign_o  = out_sign_q;
    assign out_exp_o   = out_exp_q;
    assign out_man_o   = out_man_q;
    assign out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_fp_convert_pipe.sv
// Bench for fp_convert_pipe: a rounding and a truncating instance share inputs,
// directed vectors check exact codes and latency, and a scoreboard fed from an
// arithmetic reference model checks every handshake.
module tb_fp_convert_pipe;

    localparam int IN_W    = 12;
    localparam int EXP_W   = 3;
    localparam int MAN_W   = 4;
    localparam int EXP_MAX = 7;
    localparam int MAN_MAX = 15;

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        logic             sat;
    } res_t;

    logic             clk, rst_n, in_valid, out_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_ready, in_ready_t, out_valid, out_valid_t;
    logic             sign_r, sign_t, sat_r, sat_t;
    logic [EXP_W-1:0] exp_r, exp_t;
    logic [MAN_W-1:0] man_r, man_t;
    res_t             got_r, got_t;

    assign got_r = {sign_r, exp_r, man_r, sat_r};
    assign got_t = {sign_t, exp_t, man_t, sat_t};

    fp_convert_pipe #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W), .ROUND_EN(1)) u_dut_rnd (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_sign_o(sign_r), .out_exp_o(exp_r), .out_man_o(man_r), .out_sat_o(sat_r)
    );

    fp_convert_pipe #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W), .ROUND_EN(0)) u_dut_trn (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_t),
        .in_data_i(in_data), .out_valid_o(out_valid_t), .out_ready_i(out_ready),
        .out_sign_o(sign_t), .out_exp_o(exp_t), .out_man_o(man_t), .out_sat_o(sat_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: value = man * 2^exp, with round-half-up done as floor(x/2^e + 1/2).
    function automatic res_t model(input logic [IN_W-1:0] d, input bit rnd);
        int   v, mag, p, e, m;
        res_t r;
        v   = int'($signed(d));
        mag = (v < 0) ? -v : v;
        p   = 0;
        for (int i = 0; i < IN_W; i++) if (mag >= (1 << i)) p = i;
        e = (p > MAN_W - 1) ? p - (MAN_W - 1) : 0;
        if (rnd && e > 0) m = (mag + (1 << (e - 1))) / (1 << e);
        else              m = mag / (1 << e);
        if (m > MAN_MAX) begin
            m = m / 2;
            e = e + 1;
        end
        r.s = (v < 0);
        if (e > EXP_MAX) begin
            r.e = EXP_W'(EXP_MAX); r.m = MAN_W'(MAN_MAX); r.sat = 1'b1;
        end else begin
            r.e = EXP_W'(e); r.m = MAN_W'(m); r.sat = 1'b0;
        end
        return r;
    endfunction

    // Scoreboard: push at every accept, compare at every output handshake.
    res_t q_r[$];
    res_t q_t[$];
    int   pushed = 0;
    int   popped = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_match", {31'd0, in_ready_t}, {31'd0, in_ready});
            chk("valid_match", {31'd0, out_valid_t}, {31'd0, out_valid});
            if (in_valid && in_ready) begin
                q_r.push_back(model(in_data, 1'b1));
                q_t.push_back(model(in_data, 1'b0));
                pushed++;
            end
            if (out_valid && out_ready) begin
                if (q_r.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    chk("sb_round", 32'(got_r), 32'(q_r.pop_front()));
                    chk("sb_trunc", 32'(got_t), 32'(q_t.pop_front()));
                    popped++;
                end
            end
        end
    end

    logic [IN_W-1:0] dir_in [7];
    res_t            dir_r  [7];
    res_t            dir_t  [7];
    logic [IN_W-1:0] edge_v [7];
    int              lat, cyc, sent;
    bit              acc, hold_ok;
    res_t            held;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dir_in[0] = 12'd422;  dir_r[0] = '{1'b0, 3'd5, 4'd13, 1'b0}; dir_t[0] = '{1'b0, 3'd5, 4'd13, 1'b0};
        dir_in[1] = 12'd46;   dir_r[1] = '{1'b0, 3'd2, 4'd12, 1'b0}; dir_t[1] = '{1'b0, 3'd2, 4'd11, 1'b0};
        dir_in[2] = 12'd31;   dir_r[2] = '{1'b0, 3'd2, 4'd8,  1'b0}; dir_t[2] = '{1'b0, 3'd1, 4'd15, 1'b0};
        dir_in[3] = 12'hFFB;  dir_r[3] = '{1'b1, 3'd0, 4'd5,  1'b0}; dir_t[3] = '{1'b1, 3'd0, 4'd5,  1'b0};
        dir_in[4] = 12'd0;    dir_r[4] = '{1'b0, 3'd0, 4'd0,  1'b0}; dir_t[4] = '{1'b0, 3'd0, 4'd0,  1'b0};
        dir_in[5] = 12'h7FF;  dir_r[5] = '{1'b0, 3'd7, 4'd15, 1'b1}; dir_t[5] = '{1'b0, 3'd7, 4'd15, 1'b0};
        dir_in[6] = 12'h800;  dir_r[6] = '{1'b1, 3'd7, 4'd15, 1'b1}; dir_t[6] = '{1'b1, 3'd7, 4'd15, 1'b1};
        edge_v[0] = 12'h000; edge_v[1] = 12'hFFF; edge_v[2] = 12'h7FF; edge_v[3] = 12'h800;
        edge_v[4] = 12'd15;  edge_v[5] = 12'd16;  edge_v[6] = 12'd31;

        // Reset state.
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_rnd", {22'd0, out_valid, got_r}, 32'd0);
        chk("reset_out_trn", {22'd0, out_valid_t, got_t}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Directed vectors: exact codes and three-edge latency.
        for (int k = 0; k < 7; k++) begin
            in_data  = dir_in[k];
            in_valid = 1'b1;
            chk("dir_in_ready", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 8) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("dir_latency", lat, 32'd3);
            chk("dir_round", 32'(got_r), 32'(dir_r[k]));
            chk("dir_trunc", 32'(got_t), 32'(dir_t[k]));
            @(posedge clk); #1;
        end

        // Back-to-back stream 1..20 with a 5-cycle output stall.
        sent = 1; cyc = 0; hold_ok = 1'b0;
        in_valid = 1'b1; in_data = 12'd1;
        while (sent <= 20 && cyc < 200) begin
            out_ready = !(cyc >= 6 && cyc < 11);
            @(negedge clk);
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                if (hold_ok) chk("stall_hold", 32'(got_r), 32'(held));
                else begin
                    held    = got_r;
                    hold_ok = 1'b1;
                end
            end else begin
                hold_ok = 1'b0;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                in_data = IN_W'(sent);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_all_sent", sent, 32'd21);
        repeat (6) @(posedge clk);
        #1;
        chk("stream_drained", q_r.size(), 32'd0);
        chk("stream_push_pop", popped, pushed);

        // Random traffic with random back-pressure and boundary values mixed in.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = IN_W'($urandom_range(0, 4095));
            if ($urandom_range(0, 4) == 0) in_data = edge_v[$urandom_range(0, 6)];
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("random_drained", q_r.size(), 32'd0);
        chk("random_push_pop", popped, pushed);

        // Reset pulse with three samples in flight.
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = IN_W'(100 + k * 37);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("inflight_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_rnd", {22'd0, out_valid, got_r}, 32'd0);
        chk("async_reset_trn", {22'd0, out_valid_t, got_t}, 32'd0);
        q_r.delete();
        q_t.delete();
        popped = pushed;
        #10 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("no_stale_output", {31'd0, out_valid}, 32'd0);
        end
        in_data  = 12'hA5C;
        in_valid = 1'b1;
        chk("post_reset_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("post_reset_latency", lat, 32'd3);
        chk("post_reset_value", 32'(got_r), 32'(model(12'hA5C, 1'b1)));
        repeat (3) @(posedge clk);
        #1;
        chk("final_drained", q_r.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
